// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam logic [ADDR_W-1:0]  PC_INC   = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HOLD,
        ADV,
        ERR
    } fetch_state_t;

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] addr);
        return addr + PC_INC;
    endfunction

    function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read channel and decode-side ir buffer handshake.
interface fetch_ctrl_if;
    import fetch_pkg::*;

    logic               mem_rd;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_done;
    logic [INSTR_W-1:0] mem_data;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  ir_pc4;
    logic               ir_valid;
    logic               ir_ready;

    modport master (
        output mem_rd, mem_addr, ir, ir_pc4, ir_valid,
        input  mem_done, mem_data, ir_ready
    );

    modport slave (
        input  mem_rd, mem_addr, ir, ir_pc4, ir_valid,
        output mem_done, mem_data, ir_ready
    );

endinterface

// File: rtl/fetch_obuf.sv
// Single-entry ir/ir_pc4 output buffer with a one-word hold register for
// words that arrive while decode has not yet taken the current one.
module fetch_obuf
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               clr,
    input  logic               flush,
    input  logic               load,
    input  logic               stash,
    input  logic               xfer,
    input  logic [INSTR_W-1:0] load_word,
    input  logic [ADDR_W-1:0]  load_pc4,
    input  logic               ready,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc4,
    output logic               ir_valid,
    output logic               slot_free
);

    logic [INSTR_W-1:0] hold_word;
    logic [ADDR_W-1:0]  hold_pc4;

    assign slot_free = !ir_valid || ready;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hold_word <= NOP_WORD;
            hold_pc4  <= '0;
        end else if (stash) begin
            hold_word <= load_word;
            hold_pc4  <= load_pc4;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ir     <= NOP_WORD;
            ir_pc4 <= '0;
        end else if (load) begin
            ir     <= load_word;
            ir_pc4 <= load_pc4;
        end else if (xfer) begin
            ir     <= hold_word;
            ir_pc4 <= hold_pc4;
        end
    end

    // A flush beats both a same-cycle reload and a same-cycle accept.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ir_valid <= 1'b0;
        end else if (flush) begin
            ir_valid <= 1'b0;
        end else if (load || xfer) begin
            ir_valid <= 1'b1;
        end else if (ready) begin
            ir_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: pc -> imem read -> single-entry ir buffer.
// Optional fetch timeout fault enabled by defining FETCH_TIMEOUT_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int TO_W        = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [ADDR_W-1:0] pc,
    input  logic              branch,
    input  logic              jump,
    output logic              pc_enable,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              fetch_err,
    fetch_ctrl_if.master      bus
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << TO_W)) begin : g_cfg_check
        $error("fetch_ctrl: TIMEOUT_CYC must be in 1 .. 2**TO_W-1");
    end

    fetch_state_t state, state_nxt;

    logic redirect;
    logic flush_pend, flush_nxt;
    logic err_set;
    logic load, stash, xfer;
    logic slot_free;
    logic mem_rd;

    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  ir_pc4;
    logic               ir_valid;

    assign redirect = branch | jump;
    assign pc_plus4 = next_pc(pc);

`ifdef FETCH_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    // Cleared whenever outside FETCH, so every FETCH entry starts from zero.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            to_cnt <= '0;
        end else if (state != FETCH) begin
            to_cnt <= '0;
        end else if (!bus.mem_done) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    logic to_hit;
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            flush_pend <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_pend <= flush_nxt;
            if (err_set) begin
                fetch_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        flush_nxt = flush_pend;
        err_set   = 1'b0;
        mem_rd    = 1'b0;
        pc_enable = 1'b0;
        load      = 1'b0;
        stash     = 1'b0;
        xfer      = 1'b0;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                if (misaligned(pc)) begin
                    state_nxt = ERR;
                    err_set   = 1'b1;
                end else begin
                    mem_rd = 1'b1;
                    if (bus.mem_done) begin
                        if (flush_pend || redirect) begin
                            state_nxt = ADV;
                        end else if (slot_free) begin
                            load      = 1'b1;
                            state_nxt = ADV;
                        end else begin
                            stash     = 1'b1;
                            state_nxt = HOLD;
                        end
                    end else if (to_hit) begin
                        state_nxt = ERR;
                        err_set   = 1'b1;
                    end else if (redirect) begin
                        // The request is already out; remember to drop its word.
                        flush_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_nxt = ADV;
                end else if (slot_free) begin
                    xfer      = 1'b1;
                    state_nxt = ADV;
                end
            end
            ADV: begin
                pc_enable = 1'b1;
                flush_nxt = 1'b0;
                state_nxt = FETCH;
            end
            ERR: state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    fetch_obuf u_obuf (
        .clk       (clk),
        .clr       (clr),
        .flush     (redirect),
        .load      (load),
        .stash     (stash),
        .xfer      (xfer),
        .load_word (bus.mem_data),
        .load_pc4  (pc_plus4),
        .ready     (bus.ir_ready),
        .ir        (ir),
        .ir_pc4    (ir_pc4),
        .ir_valid  (ir_valid),
        .slot_free (slot_free)
    );

    assign bus.mem_rd   = mem_rd;
    assign bus.mem_addr = mem_rd ? pc : '0;
    assign bus.ir       = ir;
    assign bus.ir_pc4   = ir_pc4;
    assign bus.ir_valid = ir_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl; define FETCH_TIMEOUT_EN to
// exercise the timeout fault with TIMEOUT_CYC=4.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic        clk;
    logic        clr;
    logic [31:0] pc;
    logic        branch;
    logic        jump;
    logic        pc_enable;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    int n_assert = 0;
    int n_fail   = 0;

    fetch_ctrl_if bus ();

`ifdef FETCH_TIMEOUT_EN
    fetch_ctrl #(.TIMEOUT_CYC(4), .TO_W(8)) dut (
`else
    fetch_ctrl #(.TIMEOUT_CYC(255), .TO_W(8)) dut (
`endif
        .clk       (clk),
        .clr       (clr),
        .pc        (pc),
        .branch    (branch),
        .jump      (jump),
        .pc_enable (pc_enable),
        .pc_plus4  (pc_plus4),
        .fetch_err (fetch_err),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        clr = 1'b1;
        pc = 32'h0;
        branch = 1'b0;
        jump = 1'b0;
        bus.mem_done = 1'b0;
        bus.mem_data = 32'h0;
        bus.ir_ready = 1'b1;
        tick();
        tick();
        chk("rst_mem_rd",    32'(bus.mem_rd), 32'h0);
        chk("rst_mem_addr",  bus.mem_addr, 32'h0);
        chk("rst_pc_enable", 32'(pc_enable), 32'h0);
        chk("rst_ir",        bus.ir, 32'h0);
        chk("rst_ir_pc4",    bus.ir_pc4, 32'h0);
        chk("rst_ir_valid",  32'(bus.ir_valid), 32'h0);
        chk("rst_fetch_err", 32'(fetch_err), 32'h0);

        // Basic fetch at 0x0 with a one-cycle memory.
        clr = 1'b0;
        tick();
        chk("f0_mem_rd",   32'(bus.mem_rd), 32'h1);
        chk("f0_mem_addr", bus.mem_addr, 32'h0);
        bus.mem_done = 1'b1;
        bus.mem_data = 32'hA1A1_0001;
        tick();
        chk("f0_ir",        bus.ir, 32'hA1A1_0001);
        chk("f0_ir_pc4",    bus.ir_pc4, 32'h4);
        chk("f0_ir_valid",  32'(bus.ir_valid), 32'h1);
        chk("f0_pc_enable", 32'(pc_enable), 32'h1);
        chk("f0_adv_mem_rd", 32'(bus.mem_rd), 32'h0);
        bus.mem_done = 1'b0;
        tick();
        pc = 32'h4;
        #1;
        chk("f0_pulse_once", 32'(pc_enable), 32'h0);
        chk("f1_mem_addr",   bus.mem_addr, 32'h4);
        chk("f0_accepted",   32'(bus.ir_valid), 32'h0);

        // Second word loads, then decode stalls and a third word parks in HOLD.
        bus.mem_done = 1'b1;
        bus.mem_data = 32'hA2A2_0002;
        tick();
        chk("f1_ir", bus.ir, 32'hA2A2_0002);
        bus.mem_done = 1'b0;
        bus.ir_ready = 1'b0;
        tick();
        pc = 32'h8;
        bus.mem_done = 1'b1;
        bus.mem_data = 32'hA3A3_0003;
        tick();
        bus.mem_done = 1'b0;
        chk("hold_mem_rd",    32'(bus.mem_rd), 32'h0);
        chk("hold_pc_enable", 32'(pc_enable), 32'h0);
        chk("hold_ir_kept",   bus.ir, 32'hA2A2_0002);
        chk("hold_valid",     32'(bus.ir_valid), 32'h1);
        tick();
        tick();
        chk("hold2_mem_rd",    32'(bus.mem_rd), 32'h0);
        chk("hold2_pc_enable", 32'(pc_enable), 32'h0);
        bus.ir_ready = 1'b1;
        tick();
        chk("xfer_ir",        bus.ir, 32'hA3A3_0003);
        chk("xfer_ir_pc4",    bus.ir_pc4, 32'hC);
        chk("xfer_valid",     32'(bus.ir_valid), 32'h1);
        chk("xfer_pc_enable", 32'(pc_enable), 32'h1);
        bus.ir_ready = 1'b0;
        tick();

        // Branch while a request is outstanding: word dropped, redirect to 0x40.
        pc = 32'hC;
        branch = 1'b1;
        tick();
        chk("br_flush_valid", 32'(bus.ir_valid), 32'h0);
        chk("br_mem_rd",      32'(bus.mem_rd), 32'h1);
        chk("br_no_adv",      32'(pc_enable), 32'h0);
        tick();
        tick();
        bus.mem_done = 1'b1;
        bus.mem_data = 32'hBAD0_BAD0;
        bus.ir_ready = 1'b1;
        tick();
        chk("br_drop_ir",   bus.ir, 32'hA3A3_0003);
        chk("br_drop_valid", 32'(bus.ir_valid), 32'h0);
        chk("br_pc_enable", 32'(pc_enable), 32'h1);
        bus.mem_done = 1'b0;
        tick();
        pc = 32'h40;
        branch = 1'b0;
        #1;
        chk("br_pulse_once", 32'(pc_enable), 32'h0);
        chk("br_target",     bus.mem_addr, 32'h40);
        bus.mem_done = 1'b1;
        bus.mem_data = 32'hA4A4_0004;
        tick();
        chk("tgt_ir",     bus.ir, 32'hA4A4_0004);
        chk("tgt_ir_pc4", bus.ir_pc4, 32'h44);
        chk("tgt_valid",  32'(bus.ir_valid), 32'h1);

        // mem_done during ADV is ignored.
        bus.mem_data = 32'hBAD1_BAD1;
        tick();
        bus.mem_done = 1'b0;
        chk("adv_done_ignored", bus.ir, 32'hA4A4_0004);
        chk("adv_accept",       32'(bus.ir_valid), 32'h0);

        pc = 32'hFFFF_FFFC;
        #1;
        chk("wrap_pc_plus4", pc_plus4, 32'h0);
        chk("wrap_mem_addr", bus.mem_addr, 32'hFFFF_FFFC);

        // Misaligned pc: fault, no request, no advance.
        pc = 32'h6;
        #1;
        chk("mis_mem_rd",   32'(bus.mem_rd), 32'h0);
        chk("mis_mem_addr", bus.mem_addr, 32'h0);
        chk("mis_pc_plus4", pc_plus4, 32'hA);
        tick();
        chk("mis_fetch_err", 32'(fetch_err), 32'h1);
        bus.mem_done = 1'b1;
        tick();
        tick();
        chk("err_mem_rd",    32'(bus.mem_rd), 32'h0);
        chk("err_pc_enable", 32'(pc_enable), 32'h0);
        chk("err_sticky",    32'(fetch_err), 32'h1);
        chk("err_ir_kept",   bus.ir, 32'hA4A4_0004);
        bus.mem_done = 1'b0;

        // clr clears the fault; restart at 0x10.
        clr = 1'b1;
        #1;
        chk("clr_fetch_err", 32'(fetch_err), 32'h0);
        chk("clr_ir",        bus.ir, 32'h0);
        pc = 32'h10;
        tick();
        clr = 1'b0;
        tick();
        chk("rs_mem_rd",   32'(bus.mem_rd), 32'h1);
        chk("rs_mem_addr", bus.mem_addr, 32'h10);

        // Asynchronous clr in the middle of a FETCH cycle.
        #2;
        clr = 1'b1;
        #1;
        chk("aclr_mem_rd",   32'(bus.mem_rd), 32'h0);
        chk("aclr_mem_addr", bus.mem_addr, 32'h0);
        chk("aclr_pc_en",    32'(pc_enable), 32'h0);
        bus.mem_done = 1'b1;
        bus.mem_data = 32'hBAD2_BAD2;
        tick();
        clr = 1'b0;
        tick();
        chk("post_clr_ir",     bus.ir, 32'h0);
        chk("post_clr_valid",  32'(bus.ir_valid), 32'h0);
        chk("post_clr_mem_rd", 32'(bus.mem_rd), 32'h1);
        bus.mem_done = 1'b0;

`ifdef FETCH_TIMEOUT_EN
        tick();
        tick();
        tick();
        chk("to_not_yet", 32'(fetch_err), 32'h0);
        tick();
        chk("to_fetch_err", 32'(fetch_err), 32'h1);
        chk("to_mem_rd",    32'(bus.mem_rd), 32'h0);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
        end
        chk("wait_fetch_err", 32'(fetch_err), 32'h0);
        chk("wait_mem_rd",    32'(bus.mem_rd), 32'h1);
        chk("wait_mem_addr",  bus.mem_addr, 32'h10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
